hps_tx_engine: RTL

//  Far end of the HPS driver's transmit interface: buffers bytes pushed via data_tx/wren_fifo_tx,
//  and on a start_tx pulse serialises size_fifo_tx bytes onto a UART-style 8N1 line.

---
 rtl/hps_tx_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hps_tx_engine.sv
// rtl/hps_tx_engine.sv - byte FIFO plus UART-style 8N1 serialiser; define TX_PARITY_EN for an even parity bit
module hps_tx_engine #(
    parameter int ADDR_W  = 8,
    parameter int CLK_DIV = 434
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        data_tx,
    input  logic              wren_fifo_tx,
    input  logic [7:0]        size_fifo_tx,
    input  logic              start_tx,
    output logic              ready_tx,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow,
    output logic              tx_serial,
    output logic              tx_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Frame length counter must hold both the 8-bit size and the full FIFO level.
    localparam int LW    = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;
    localparam int TW    = $clog2(CLK_DIV);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_DONE} state_t;
`endif

    state_t            state, next_state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   level;
    logic              overflow_q;
    logic              start_q;
    logic [LW-1:0]     remaining;
    logic [7:0]        shift_byte;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_idx, idx_next;
    logic              line, line_next;

    logic              full, wr_en, pop, start_re, accept, timer_last, in_bit;
    logic [LW-1:0]     size_w, level_w, eff_len;

    assign full       = (level == (ADDR_W + 1)'(DEPTH));
    assign wr_en      = wren_fifo_tx && !full;
    assign pop        = (state == S_LOAD);
    assign start_re   = start_tx & ~start_q;
    assign accept     = start_re && (state == S_IDLE);
    assign size_w     = LW'(size_fifo_tx);
    assign level_w    = LW'(level);
    assign eff_len    = (size_w < level_w) ? size_w : level_w;
    assign timer_last = (timer == TW'(CLK_DIV - 1));
`ifdef TX_PARITY_EN
    assign in_bit     = (state == S_START) || (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);
`else
    assign in_bit     = (state == S_START) || (state == S_DATA) || (state == S_STOP);
`endif

    assign ready_tx   = (state == S_IDLE);
    assign tx_done    = (state == S_DONE);
    assign fifo_level = level;
    assign overflow   = overflow_q;
    assign tx_serial  = line;

    // FIFO pointers, occupancy and sticky overflow; a start accept clears overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (accept)              overflow_q <= 1'b0;
            if (wren_fifo_tx && full) overflow_q <= 1'b1;
        end
    end

    // FIFO storage, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_tx;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // Next state, next bit index and the value the line takes next cycle
    always_comb begin
        next_state = state;
        idx_next   = bit_idx;
        line_next  = 1'b1;
        case (state)
            S_IDLE:  if (accept && eff_len != '0) next_state = S_LOAD;
            S_LOAD:  next_state = S_START;
            S_START: if (timer_last) begin
                         next_state = S_DATA;
                         idx_next   = 3'd0;
                     end
            S_DATA:  if (timer_last) begin
                         idx_next = bit_idx + 3'd1;
`ifdef TX_PARITY_EN
                         if (bit_idx == 3'd7) next_state = S_PARITY;
`else
                         if (bit_idx == 3'd7) next_state = S_STOP;
`endif
                     end
`ifdef TX_PARITY_EN
            S_PARITY: if (timer_last) next_state = S_STOP;
`endif
            S_STOP:  if (timer_last) next_state = (remaining != '0) ? S_LOAD : S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        case (next_state)
            S_START:  line_next = 1'b0;
            S_DATA:   line_next = shift_byte[idx_next];
`ifdef TX_PARITY_EN
            S_PARITY: line_next = ^shift_byte;
`endif
            default:  line_next = 1'b1;
        endcase
    end

    // Datapath: start edge detect, byte count, shift byte, bit timer and registered line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q    <= 1'b0;
            remaining  <= '0;
            shift_byte <= '0;
            timer      <= '0;
            bit_idx    <= '0;
            line       <= 1'b1;
        end else begin
            start_q <= start_tx;
            if (accept)   remaining <= eff_len;
            else if (pop) remaining <= remaining - LW'(1);
            if (pop) shift_byte <= mem[rd_ptr];
            if (in_bit && !timer_last) timer <= timer + 1'b1;
            else                       timer <= '0;
            bit_idx <= idx_next;
            line    <= line_next;
        end
    end

endmodule
